// File: rtl/vga_window_addr_gen.sv
// vga_window_addr_gen
// Maps raster coordinates onto a centred image window and produces the
// frame-buffer read address for each pixel. The window size and the 2x zoom
// setting are taken from shadow registers that are loaded on the last visible
// pixel of a frame, so a frame never sees a configuration change part-way
// through. Two pipeline stages: window test / relative coordinates, then the
// row*width+column multiply-add.

module vga_window_addr_gen #(
    parameter int H_DISPLAY = 640,
    parameter int V_DISPLAY = 480,
    parameter int WIDTH_W   = 10,
    parameter int HEIGHT_W  = 9,
    parameter int ADDR_W    = 17
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                PIX_EN,
    input  logic [9:0]          X_CUR_COORD,
    input  logic [9:0]          Y_CUR_COORD,
    input  logic [WIDTH_W-1:0]  IMG_WIDTH_OUT,
    input  logic [HEIGHT_W-1:0] IMG_HEIGHT_OUT,
    input  logic                ZOOM_2X,
    output logic                CUR_COORD_STATE,
    output logic [ADDR_W-1:0]   R_ADDR,
    output logic                OUT_VALID,
    output logic                CFG_ERR
);

    // All window geometry is evaluated at 11 bits so that W<<1 and H<<1
    // never lose their top bit.
    localparam int CW     = 11;
    localparam int PROD_W = CW + WIDTH_W + 1;

    localparam logic [CW-1:0] H_DISP = CW'(H_DISPLAY);
    localparam logic [CW-1:0] V_DISP = CW'(V_DISPLAY);
    localparam logic [9:0]    X_LAST = 10'(H_DISPLAY - 1);
    localparam logic [9:0]    Y_LAST = 10'(V_DISPLAY - 1);

    // ------------------------------------------------------------------
    // Configuration check shared by the datapath (current shadow) and the
    // error flag (shadow as it will be after this clock edge).
    // ------------------------------------------------------------------
    function automatic logic cfg_bad(
        input logic [WIDTH_W-1:0]  w,
        input logic [HEIGHT_W-1:0] h,
        input logic                z
    );
        logic [CW-1:0] ew;
        logic [CW-1:0] eh;
        ew = CW'(w) << z;
        eh = CW'(h) << z;
        return (w == '0) || (h == '0) || (ew > H_DISP) || (eh > V_DISP);
    endfunction

    // ------------------------------------------------------------------
    // Shadow configuration
    // ------------------------------------------------------------------
    logic [WIDTH_W-1:0]  w_shadow_reg;
    logic [WIDTH_W-1:0]  w_shadow_next;
    logic [HEIGHT_W-1:0] h_shadow_reg;
    logic [HEIGHT_W-1:0] h_shadow_next;
    logic                z_shadow_reg;
    logic                z_shadow_next;
    logic                cfg_err_reg;
    logic                latch_cfg;

    // The last visible pixel of a frame is the only point where the live
    // configuration inputs are sampled.
    assign latch_cfg = PIX_EN && (X_CUR_COORD == X_LAST) && (Y_CUR_COORD == Y_LAST);

    // Select between holding the shadow values and loading the live inputs.
    always_comb begin
        w_shadow_next = w_shadow_reg;
        h_shadow_next = h_shadow_reg;
        z_shadow_next = z_shadow_reg;
        if (latch_cfg) begin
            w_shadow_next = IMG_WIDTH_OUT;
            h_shadow_next = IMG_HEIGHT_OUT;
            z_shadow_next = ZOOM_2X;
        end
    end

    // Shadow registers and the error flag; the flag is judged on the value
    // being loaded so it reflects a new configuration one cycle after the latch.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            w_shadow_reg <= '0;
            h_shadow_reg <= '0;
            z_shadow_reg <= 1'b0;
            cfg_err_reg  <= 1'b0;
        end else begin
            w_shadow_reg <= w_shadow_next;
            h_shadow_reg <= h_shadow_next;
            z_shadow_reg <= z_shadow_next;
            cfg_err_reg  <= cfg_bad(w_shadow_next, h_shadow_next, z_shadow_next);
        end
    end

    // ------------------------------------------------------------------
    // Stage 0 (combinational): window geometry and inside test
    // ------------------------------------------------------------------
    logic [CW-1:0] eff_w;
    logic [CW-1:0] eff_h;
    logic [CW-1:0] h_off;
    logic [CW-1:0] v_off;
    logic [CW-1:0] x_ext;
    logic [CW-1:0] y_ext;
    logic          cfg_ok;
    logic          in_x;
    logic          in_y;
    logic          inside_next;
    logic [CW-1:0] rx_next;
    logic [CW-1:0] ry_next;

    assign cfg_ok = !cfg_bad(w_shadow_reg, h_shadow_reg, z_shadow_reg);
    assign x_ext  = CW'(X_CUR_COORD);
    assign y_ext  = CW'(Y_CUR_COORD);

    // Centre the effective window; odd margins round the offset down. The
    // explicit raster-limit terms keep off-screen coordinates outside even
    // though a valid window never extends past the display edge.
    always_comb begin
        eff_w       = CW'(w_shadow_reg) << z_shadow_reg;
        eff_h       = CW'(h_shadow_reg) << z_shadow_reg;
        h_off       = (H_DISP - eff_w) >> 1;
        v_off       = (V_DISP - eff_h) >> 1;
        in_x        = (x_ext >= h_off) && (x_ext < h_off + eff_w) && (x_ext < H_DISP);
        in_y        = (y_ext >= v_off) && (y_ext < v_off + eff_h) && (y_ext < V_DISP);
        inside_next = cfg_ok && in_x && in_y;
        rx_next     = '0;
        ry_next     = '0;
        if (inside_next) begin
            rx_next = (x_ext - h_off) >> z_shadow_reg;
            ry_next = (y_ext - v_off) >> z_shadow_reg;
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: inside flag, relative coordinates, valid bit. The image width
    // travels with the pixel so a latch between stages cannot change the
    // row pitch of a pixel already in flight.
    // ------------------------------------------------------------------
    logic               valid_s1_reg;
    logic               inside_s1_reg;
    logic [CW-1:0]      rx_s1_reg;
    logic [CW-1:0]      ry_s1_reg;
    logic [WIDTH_W-1:0] w_s1_reg;

    // Capture stage-0 results; data only moves on valid pixels.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            valid_s1_reg  <= 1'b0;
            inside_s1_reg <= 1'b0;
            rx_s1_reg     <= '0;
            ry_s1_reg     <= '0;
            w_s1_reg      <= '0;
        end else begin
            valid_s1_reg <= PIX_EN;
            if (PIX_EN) begin
                inside_s1_reg <= inside_next;
                rx_s1_reg     <= rx_next;
                ry_s1_reg     <= ry_next;
                w_s1_reg      <= w_shadow_reg;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: multiply-add and output registers
    // ------------------------------------------------------------------
    logic [PROD_W-1:0] addr_full;
    logic              valid_s2_reg;
    logic              inside_s2_reg;
    logic [ADDR_W-1:0] addr_s2_reg;

    assign addr_full = PROD_W'(ry_s1_reg) * PROD_W'(w_s1_reg) + PROD_W'(rx_s1_reg);

    // Outputs hold their last value across idle cycles; only a valid
    // stage-1 entry updates them.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            valid_s2_reg  <= 1'b0;
            inside_s2_reg <= 1'b0;
            addr_s2_reg   <= '0;
        end else begin
            valid_s2_reg <= valid_s1_reg;
            if (valid_s1_reg) begin
                inside_s2_reg <= inside_s1_reg;
                addr_s2_reg   <= inside_s1_reg ? ADDR_W'(addr_full) : '0;
            end
        end
    end

    assign CUR_COORD_STATE = inside_s2_reg;
    assign R_ADDR          = addr_s2_reg;
    assign OUT_VALID       = valid_s2_reg;
    assign CFG_ERR         = cfg_err_reg;

endmodule

// File: doc/vga_window_addr_gen.md
VGA_WINDOW_ADDR_GEN -- requirements
Module: vga_window_addr_gen

Interface
REQ-001 Parameter H_DISPLAY, default 640, visible pixels per line.
REQ-002 Parameter V_DISPLAY, default 480, visible lines per frame.
REQ-003 Parameter WIDTH_W, default 10, bit width of IMG_WIDTH_OUT.
REQ-004 Parameter HEIGHT_W, default 9, bit width of IMG_HEIGHT_OUT.
REQ-005 Parameter ADDR_W, default 17, bit width of R_ADDR.
REQ-006 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-007 Port CLK, input, 1 bit, system clock.
REQ-008 Port RST_N, input, 1 bit, asynchronous active-low reset.
REQ-009 Port PIX_EN, input, 1 bit, the current coordinates are valid this cycle.
REQ-010 Port X_CUR_COORD, input, 10 bits, current column.
REQ-011 Port Y_CUR_COORD, input, 10 bits, current line.
REQ-012 Port IMG_WIDTH_OUT, input, WIDTH_W bits, source image width W.
REQ-013 Port IMG_HEIGHT_OUT, input, HEIGHT_W bits, source image height H.
REQ-014 Port ZOOM_2X, input, 1 bit, 0 = 1:1 display, 1 = 2x2 pixel replication.
REQ-015 Port CUR_COORD_STATE, output, 1 bit, the pixel is inside the image window.
REQ-016 Port R_ADDR, output, ADDR_W bits, frame-buffer read address.
REQ-017 Port OUT_VALID, output, 1 bit, CUR_COORD_STATE and R_ADDR are valid.
REQ-018 Port CFG_ERR, output, 1 bit, the active configuration is invalid.

Function
REQ-019 Configuration is shadow-latched. On a PIX_EN cycle with X = H_DISPLAY-1 and Y = V_DISPLAY-1, the block SHALL register W, H and Z (ZOOM_2X) into shadow registers; the latched values take effect from the next frame.
REQ-020 Changes to W, H or ZOOM_2X at any other time SHALL have no effect.
REQ-021 Effective window size: EW = W<<Z and EH = H<<Z, computed at 11 bits with no truncation.
REQ-022 The shadow configuration is invalid if W = 0, H = 0, EW > H_DISPLAY or EH > V_DISPLAY.
REQ-023 While the shadow configuration is invalid: CFG_ERR = 1, CUR_COORD_STATE = 0 and R_ADDR = 0 on every valid output.
REQ-024 Offsets: HO = (H_DISPLAY-EW)>>1 and VO = (V_DISPLAY-EH)>>1, computed from the shadow registers and floored.
REQ-025 Inside test: HO <= X < HO+EW and VO <= Y < VO+EH, compared at 11 bits.
REQ-026 Relative coordinates: rx = (X-HO)>>Z and ry = (Y-VO)>>Z.
REQ-027 Address: R_ADDR = ry*W + rx, truncated to ADDR_W bits, when inside; R_ADDR = 0 when outside.
REQ-028 Pipeline stage 1 SHALL register the inside flag, rx, ry and PIX_EN.
REQ-029 Pipeline stage 2 SHALL register the multiply-add result, the inside flag and the valid bit.
REQ-030 Latency: the outputs for the coordinates presented with PIX_EN in cycle n SHALL appear in cycle n+2, with OUT_VALID = 1.
REQ-031 OUT_VALID SHALL be PIX_EN delayed by exactly 2 cycles.
REQ-032 When OUT_VALID = 0, CUR_COORD_STATE and R_ADDR SHALL hold their previous values.
REQ-033 PIX_EN may toggle every cycle; back-to-back pixels SHALL be accepted with no stalls.
REQ-034 When the latch condition and an in-window pixel occur in the same cycle, that pixel SHALL use the old shadow configuration.
REQ-035 Coordinates with X >= H_DISPLAY or Y >= V_DISPLAY SHALL be reported outside with R_ADDR = 0.
REQ-036 CFG_ERR SHALL update in the cycle after the shadow latch.

Reset
REQ-037 While RST_N = 0, all outputs SHALL be 0 asynchronously: CUR_COORD_STATE, R_ADDR, OUT_VALID, CFG_ERR.
REQ-038 While RST_N = 0, the shadow W, H and Z registers and all pipeline registers SHALL be 0.
REQ-039 After reset the shadow W = 0, so CFG_ERR = 1 and the window is disabled until the first latch.
REQ-040 Reset asserted mid-frame SHALL discard in-flight pipeline data; OUT_VALID stays 0 until 2 cycles after the first PIX_EN following release.

Verification
REQ-041 1:1 centring: W=320, H=240, Z=0 latched, then scan the next frame. Required: (159,120) -> state 0, addr 0; (160,120) -> state 1, addr 0; (479,359) -> state 1, addr 76799; (480,120) -> state 0, addr 0. Every result appears 2 cycles after its PIX_EN.
REQ-042 2x zoom: W=320, H=240, Z=1. Required: HO=0, VO=0; (0,0) and (1,1) -> addr 0; (2,0) -> addr 1; (0,2) -> addr 320; (639,479) -> addr 76799.
REQ-043 Odd size: W=101, H=51, Z=0. Required: HO=269, VO=214; (269,214) -> addr 0; (369,264) -> addr 5150; (370,264) -> state 0.
REQ-044 Invalid configuration: W=700, or W=400 with Z=1, or H=0. Required: after the latch, CFG_ERR = 1 and CUR_COORD_STATE = 0 for the whole frame. A later valid latch clears CFG_ERR.
REQ-045 Shadowing and reset:
- Change W mid-frame. Required: addresses unchanged until the next frame.
- Assert RST_N = 0 mid-line with PIX_EN continuous. Required: outputs go to 0 immediately; OUT_VALID returns 2 cycles after release.
- Randomised raster stream. Required: every output matches the reference model in REQ-021 to REQ-027.
